// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-based round-robin sharing of a single UART byte
// transmitter among N_REQ requesters. A granted requester keeps the
// transmitter until its last byte has gone out, or until it leaves its
// request low for HOLD_TO cycles in the middle of a packet.
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int HOLD_TO = 1024
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic [N_REQ-1:0]   i_Req,
    input  logic [8*N_REQ-1:0] i_Data,
    input  logic [N_REQ-1:0]   i_Last,
    output logic [N_REQ-1:0]   o_Grant,
    output logic [N_REQ-1:0]   o_Ack,
    output logic [N_REQ-1:0]   o_Abort,
    output logic               o_TxStart,
    output logic [7:0]         o_TxData,
    input  logic               i_TxBusy
);

    localparam int PW = $clog2(N_REQ);
    localparam int HW = $clog2(HOLD_TO + 1);

    // Counter value at which the next idle cycle reaches HOLD_TO.
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TO - 1);
    localparam logic [HW-1:0] HOLD_ONE  = HW'(1);
    // Pointer parks on the highest index so requester 0 is scanned first.
    localparam logic [PW-1:0] PTR_RST   = PW'(N_REQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOAD    = 2'd1,
        ST_WAIT_HI = 2'd2,
        ST_WAIT_LO = 2'd3
    } state_t;

    state_t             state_q,   state_d;
    logic [N_REQ-1:0]   grant_q,   grant_d;
    logic [N_REQ-1:0]   ack_q,     ack_d;
    logic [N_REQ-1:0]   abort_q,   abort_d;
    logic               start_q,   start_d;
    logic [7:0]         txdata_q,  txdata_d;
    logic [PW-1:0]      ptr_q,     ptr_d;
    logic               last_q,    last_d;
    logic [HW-1:0]      hold_q,    hold_d;

    logic [PW-1:0]      gidx_s;
    logic               sel_req_s;
    logic               sel_last_s;
    logic [7:0]         sel_data_s;
    logic [N_REQ-1:0]   rr_pick_s;

    // First set request bit strictly after ptr, wrapping around; one-hot.
    function automatic logic [N_REQ-1:0] rr_pick(input logic [N_REQ-1:0] req,
                                                 input logic [PW-1:0]    ptr);
        logic [N_REQ-1:0] pick;
        logic             found;
        int               idx;
        pick  = {N_REQ{1'b0}};
        found = 1'b0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(ptr) + i >= N_REQ) ? (int'(ptr) + i - N_REQ) : (int'(ptr) + i);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
        return pick;
    endfunction

    // Binary index of a one-hot vector (OR-encoded, zero for an empty vector).
    function automatic logic [PW-1:0] onehot_idx(input logic [N_REQ-1:0] oh);
        logic [PW-1:0] r;
        r = {PW{1'b0}};
        for (int k = 0; k < N_REQ; k++) begin
            r = r | (PW'(k) & {PW{oh[k]}});
        end
        return r;
    endfunction

    // AND-OR select of the byte slice belonging to the one-hot owner.
    function automatic logic [7:0] slice_sel(input logic [8*N_REQ-1:0] data,
                                             input logic [N_REQ-1:0]   oh);
        logic [7:0] r;
        r = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            r = r | (data[8*k +: 8] & {8{oh[k]}});
        end
        return r;
    endfunction

    assign gidx_s     = onehot_idx(grant_q);
    assign sel_req_s  = |(i_Req & grant_q);
    assign sel_last_s = |(i_Last & grant_q);
    assign sel_data_s = slice_sel(i_Data, grant_q);
    assign rr_pick_s  = rr_pick(i_Req, ptr_q);

    // Next-state and output decode of the grant/transfer FSM.
    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        ptr_d    = ptr_q;
        last_d   = last_q;
        hold_d   = hold_q;
        txdata_d = txdata_q;
        ack_d    = {N_REQ{1'b0}};
        abort_d  = {N_REQ{1'b0}};
        start_d  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (|i_Req) begin
                    grant_d = rr_pick_s;
                    hold_d  = {HW{1'b0}};
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (sel_req_s) begin
                    // Request present: the hold counter only waits for busy.
                    if (!i_TxBusy) begin
                        start_d  = 1'b1;
                        ack_d    = grant_q;
                        txdata_d = sel_data_s;
                        last_d   = sel_last_s;
                        hold_d   = {HW{1'b0}};
                        state_d  = ST_WAIT_HI;
                    end else begin
                        state_d  = ST_LOAD;
                    end
                end else if (hold_q == HOLD_LAST) begin
                    abort_d = grant_q;
                    grant_d = {N_REQ{1'b0}};
                    ptr_d   = gidx_s;
                    hold_d  = {HW{1'b0}};
                    state_d = ST_IDLE;
                end else begin
                    hold_d  = hold_q + HOLD_ONE;
                end
            end
            ST_WAIT_HI: begin
                if (i_TxBusy) begin
                    state_d = ST_WAIT_LO;
                end else begin
                    state_d = ST_WAIT_HI;
                end
            end
            ST_WAIT_LO: begin
                if (!i_TxBusy) begin
                    if (last_q) begin
                        grant_d = {N_REQ{1'b0}};
                        ptr_d   = gidx_s;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_WAIT_LO;
                end
            end
            default: begin
                grant_d = {N_REQ{1'b0}};
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs, with synchronous reset.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q  <= ST_IDLE;
            grant_q  <= {N_REQ{1'b0}};
            ack_q    <= {N_REQ{1'b0}};
            abort_q  <= {N_REQ{1'b0}};
            start_q  <= 1'b0;
            txdata_q <= 8'h00;
            ptr_q    <= PTR_RST;
            last_q   <= 1'b0;
            hold_q   <= {HW{1'b0}};
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            ack_q    <= ack_d;
            abort_q  <= abort_d;
            start_q  <= start_d;
            txdata_q <= txdata_d;
            ptr_q    <= ptr_d;
            last_q   <= last_d;
            hold_q   <= hold_d;
        end
    end

    assign o_Grant   = grant_q;
    assign o_Ack     = ack_q;
    assign o_Abort   = abort_q;
    assign o_TxStart = start_q;
    assign o_TxData  = txdata_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: per-requester byte sources, a behavioural
// transmitter busy model and an in-order scoreboard of expected bytes.
module tb_uart_tx_arbiter;

    localparam int N    = 4;
    localparam int HOLD = 16;
    localparam int SD   = 64;

    logic           Clk = 1'b0;
    logic           Rst;
    logic [N-1:0]   i_Req;
    logic [8*N-1:0] i_Data;
    logic [N-1:0]   i_Last;
    logic [N-1:0]   o_Grant;
    logic [N-1:0]   o_Ack;
    logic [N-1:0]   o_Abort;
    logic           o_TxStart;
    logic [7:0]     o_TxData;
    logic           i_TxBusy;

    typedef struct {
        int         idx;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         start_log[$];
    logic [7:0] src_data [N][SD];
    logic       src_last [N][SD];
    int         src_rd [N];
    int         src_wr [N];
    logic       req_en [N];

    int   vec_cnt = 0;
    int   err_cnt = 0;
    int   cyc = 0;
    int   fall_cyc = -1;
    int   start_cyc = -1;
    int   busy_wait = 0;
    int   busy_len = 0;
    logic model_busy = 1'b0;
    logic force_busy = 1'b0;

    assign i_TxBusy = model_busy | force_busy;

    uart_tx_arbiter #(.N_REQ(N), .HOLD_TO(HOLD)) dut (
        .Clk       (Clk),
        .Rst       (Rst),
        .i_Req     (i_Req),
        .i_Data    (i_Data),
        .i_Last    (i_Last),
        .o_Grant   (o_Grant),
        .o_Ack     (o_Ack),
        .o_Abort   (o_Abort),
        .o_TxStart (o_TxStart),
        .o_TxData  (o_TxData),
        .i_TxBusy  (i_TxBusy)
    );

    always #5 Clk = ~Clk;

    task automatic drive_inputs();
        for (int k = 0; k < N; k++) begin
            i_Req[k]         = req_en[k] && (src_rd[k] != src_wr[k]);
            i_Data[8*k +: 8] = src_data[k][src_rd[k] % SD];
            i_Last[k]        = src_last[k][src_rd[k] % SD];
        end
    endtask

    // Queue a byte at requester k and, in the same order, its expected start.
    task automatic add_byte(input int k, input logic [7:0] d, input logic l);
        src_data[k][src_wr[k] % SD] = d;
        src_last[k][src_wr[k] % SD] = l;
        src_wr[k]++;
        exp_q.push_back('{idx: k, data: d});
    endtask

    // Throw away whatever requester k has not yet had accepted.
    task automatic drop_src(input int k);
        src_rd[k] = src_wr[k];
        for (int i = exp_q.size() - 1; i >= 0; i--) begin
            if (exp_q[i].idx == k) exp_q.delete(i);
        end
    endtask

    function automatic bit is_idle();
        return (o_Grant === 4'b0000) && !model_busy && (busy_wait == 0) && (exp_q.size() == 0);
    endfunction

    // One clock: scoreboard on starts, transmitter busy model, sources advance on ack.
    task automatic tick();
        logic [N-1:0] oh;
        exp_t         e;
        int           g;
        @(posedge Clk);
        #1;
        cyc++;
        if (o_TxStart === 1'b1) begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                if (o_Grant[k] === 1'b1) g = k;
            end
            vec_cnt++;
            if (exp_q.size() == 0) begin
                err_cnt++;
                $display("FAIL sb_extra: start with grant=%b data=%h, required no start", o_Grant, o_TxData);
            end else begin
                e = exp_q.pop_front();
                oh = 4'b0000;
                oh[e.idx] = 1'b1;
                if (o_TxData !== e.data || o_Ack !== oh || o_Grant !== oh) begin
                    err_cnt++;
                    $display("FAIL sb_byte: data=%h ack=%b grant=%b, required data=%h ack=%b grant=%b",
                             o_TxData, o_Ack, o_Grant, e.data, oh, oh);
                end
            end
            start_log.push_back(g);
            start_cyc = cyc;
            busy_wait = $urandom_range(4, 1);
        end else if (busy_wait > 0) begin
            busy_wait--;
            if (busy_wait == 0) begin
                model_busy = 1'b1;
                busy_len   = $urandom_range(6, 2);
            end
        end else if (model_busy) begin
            busy_len--;
            if (busy_len == 0) begin
                model_busy = 1'b0;
                fall_cyc   = cyc;
            end
        end
        for (int k = 0; k < N; k++) begin
            if (o_Ack[k] === 1'b1) src_rd[k]++;
        end
        drive_inputs();
    endtask

    task automatic wait_idle(input string nm);
        for (int i = 0; i < 400 && !is_idle(); i++) tick();
        vec_cnt++;
        if (!is_idle()) begin
            err_cnt++;
            $display("FAIL %s_idle: grant=%b pending=%0d, required grant=0000 pending=0", nm, o_Grant, exp_q.size());
        end
    endtask

    task automatic check_order(input string nm, input int n, input int o0, input int o1,
                               input int o2, input int o3);
        int want [4];
        want = '{o0, o1, o2, o3};
        vec_cnt++;
        if (start_log.size() != n) begin
            err_cnt++;
            $display("FAIL %s_count: %0d starts, required %0d", nm, start_log.size(), n);
        end else begin
            for (int i = 0; i < n; i++) begin
                vec_cnt++;
                if (start_log[i] != want[i]) begin
                    err_cnt++;
                    $display("FAIL %s_order[%0d]: requester %0d, required %0d", nm, i, start_log[i], want[i]);
                end
            end
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        vec_cnt++;
        if (o_Grant !== 4'b0000) begin err_cnt++; $display("FAIL %s_grant: %b, required 0000", nm, o_Grant); end
        vec_cnt++;
        if (o_Ack !== 4'b0000) begin err_cnt++; $display("FAIL %s_ack: %b, required 0000", nm, o_Ack); end
        vec_cnt++;
        if (o_Abort !== 4'b0000) begin err_cnt++; $display("FAIL %s_abort: %b, required 0000", nm, o_Abort); end
        vec_cnt++;
        if (o_TxStart !== 1'b0) begin err_cnt++; $display("FAIL %s_start: %b, required 0", nm, o_TxStart); end
        vec_cnt++;
        if (o_TxData !== 8'h00) begin err_cnt++; $display("FAIL %s_data: %h, required 00", nm, o_TxData); end
    endtask

    task automatic test_reset();
        Rst = 1'b1;
        tick();
        tick();
        check_reset_outputs("reset");
        Rst = 1'b0;
        drive_inputs();
    endtask

    task automatic test_single_byte();
        bit cleared;
        fall_cyc = -1;
        add_byte(0, 8'h3C, 1'b1);
        drive_inputs();
        tick();
        vec_cnt++;
        if (o_Grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL single_grant: %b, required 0001", o_Grant);
        end
        tick();
        vec_cnt++;
        if (o_TxStart !== 1'b1 || o_Ack !== 4'b0001 || o_TxData !== 8'h3C) begin
            err_cnt++;
            $display("FAIL single_start: start=%b ack=%b data=%h, required 1 0001 3c", o_TxStart, o_Ack, o_TxData);
        end
        cleared = 1'b0;
        for (int i = 0; i < 50 && !cleared; i++) begin
            tick();
            cleared = (o_Grant === 4'b0000);
        end
        vec_cnt++;
        if (!cleared || fall_cyc < 0 || cyc != fall_cyc + 1) begin
            err_cnt++;
            $display("FAIL single_release: released=%b at cycle %0d, required release at cycle %0d", cleared, cyc, fall_cyc + 1);
        end
        wait_idle("single");
    endtask

    task automatic test_round_robin();
        Rst = 1'b1;
        tick();
        Rst = 1'b0;
        start_log.delete();
        add_byte(0, 8'hA0, 1'b1);
        add_byte(2, 8'hB0, 1'b1);
        add_byte(0, 8'hA1, 1'b1);
        add_byte(2, 8'hB1, 1'b1);
        drive_inputs();
        wait_idle("rr");
        check_order("rr", 4, 0, 2, 0, 2);
    endtask

    task automatic test_packet_lock();
        bit got;
        bit viol;
        int n1;
        start_log.delete();
        add_byte(1, 8'hE5, 1'b0);
        add_byte(1, 8'h01, 1'b0);
        add_byte(1, 8'h02, 1'b1);
        drive_inputs();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (o_Grant[1] === 1'b1);
        end
        vec_cnt++;
        if (o_Grant !== 4'b0010) begin
            err_cnt++;
            $display("FAIL lock_grant: %b, required 0010", o_Grant);
        end
        add_byte(3, 8'h77, 1'b1);
        drive_inputs();
        n1 = 0;
        viol = 1'b0;
        for (int i = 0; i < 400 && !is_idle(); i++) begin
            tick();
            if (n1 < 3 && o_Grant[3] === 1'b1) viol = 1'b1;
            if (o_TxStart === 1'b1 && o_Grant[1] === 1'b1) begin
                n1++;
                if (n1 > 1) begin
                    vec_cnt++;
                    if (start_cyc != fall_cyc + 2) begin
                        err_cnt++;
                        $display("FAIL lock_b2b: start at cycle %0d, required %0d", start_cyc, fall_cyc + 2);
                    end
                end
            end
        end
        vec_cnt++;
        if (viol) begin
            err_cnt++;
            $display("FAIL lock_hold: grant[3] seen mid-packet=%b, required 0", viol);
        end
        check_order("lock", 4, 1, 1, 1, 3);
    endtask

    task automatic test_hold_timeout();
        bit got;
        start_log.delete();
        add_byte(1, 8'hC1, 1'b0);
        add_byte(1, 8'hC2, 1'b1);
        drive_inputs();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (o_Grant[1] === 1'b1);
        end
        add_byte(2, 8'h5A, 1'b1);
        drive_inputs();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (o_Ack[1] === 1'b1);
        end
        req_en[1] = 1'b0;
        fall_cyc = -1;
        drive_inputs();
        got = 1'b0;
        for (int i = 0; i < 100 && !got; i++) begin
            tick();
            got = (o_Abort !== 4'b0000);
        end
        vec_cnt++;
        if (o_Abort !== 4'b0010) begin
            err_cnt++;
            $display("FAIL hold_abort: %b, required 0010", o_Abort);
        end
        vec_cnt++;
        if (fall_cyc < 0 || cyc != fall_cyc + 17) begin
            err_cnt++;
            $display("FAIL hold_time: abort at cycle %0d, required %0d", cyc, fall_cyc + 17);
        end
        vec_cnt++;
        if (o_Grant !== 4'b0000) begin
            err_cnt++;
            $display("FAIL hold_revoke: grant=%b, required 0000", o_Grant);
        end
        tick();
        vec_cnt++;
        if (o_Abort !== 4'b0000 || o_Grant !== 4'b0100) begin
            err_cnt++;
            $display("FAIL hold_next: abort=%b grant=%b, required 0000 0100", o_Abort, o_Grant);
        end
        drop_src(1);
        req_en[1] = 1'b1;
        drive_inputs();
        wait_idle("hold");
    endtask

    task automatic test_busy_stall();
        bit early;
        force_busy = 1'b1;
        add_byte(0, 8'h99, 1'b1);
        drive_inputs();
        tick();
        vec_cnt++;
        if (o_Grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL stall_grant: %b, required 0001", o_Grant);
        end
        early = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (o_TxStart === 1'b1) early = 1'b1;
        end
        vec_cnt++;
        if (early) begin
            err_cnt++;
            $display("FAIL stall_hold: start while busy=%b, required 0", early);
        end
        force_busy = 1'b0;
        tick();
        vec_cnt++;
        if (o_TxStart !== 1'b1 || o_TxData !== 8'h99 || o_Ack !== 4'b0001) begin
            err_cnt++;
            $display("FAIL stall_start: start=%b data=%h ack=%b, required 1 99 0001", o_TxStart, o_TxData, o_Ack);
        end
        wait_idle("stall");
    endtask

    task automatic test_reset_mid_packet();
        bit got;
        add_byte(2, 8'hD0, 1'b0);
        add_byte(2, 8'hD1, 1'b0);
        add_byte(2, 8'hD2, 1'b1);
        drive_inputs();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = (o_TxStart === 1'b1);
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            tick();
            got = model_busy;
        end
        vec_cnt++;
        if (!got) begin
            err_cnt++;
            $display("FAIL midrst_setup: busy=%b, required 1", model_busy);
        end
        tick();
        Rst = 1'b1;
        tick();
        check_reset_outputs("midrst");
        drop_src(2);
        start_log.delete();
        add_byte(0, 8'hF0, 1'b1);
        add_byte(2, 8'hF2, 1'b1);
        add_byte(3, 8'hF3, 1'b1);
        Rst = 1'b0;
        drive_inputs();
        tick();
        vec_cnt++;
        if (o_Grant !== 4'b0001) begin
            err_cnt++;
            $display("FAIL midrst_first: grant=%b, required 0001", o_Grant);
        end
        wait_idle("midrst");
        check_order("midrst", 3, 0, 2, 3, 0);
    endtask

    initial begin
        Rst = 1'b1;
        for (int k = 0; k < N; k++) begin
            src_rd[k] = 0;
            src_wr[k] = 0;
            req_en[k] = 1'b1;
            for (int j = 0; j < SD; j++) begin
                src_data[k][j] = 8'h00;
                src_last[k][j] = 1'b0;
            end
        end
        drive_inputs();
        test_reset();
        test_single_byte();
        test_round_robin();
        test_packet_lock();
        test_hold_timeout();
        test_busy_stall();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one UART byte transmitter among N_REQ requesters on a packet basis. Each requester presents bytes with a last-byte flag. The arbiter grants the transmitter round-robin, forwards each byte with a one-cycle start pulse, and holds the grant until that requester's last byte has been sent. It sits between the protocol/command blocks and the UART transmitter, the transmit-side counterpart of the receive path.

## Interface
- N_REQ, 4, number of requesters (2..8)
- HOLD_TO, 1024, cycles a granted requester may leave its request low mid-packet before the grant is revoked

- Clk  input  1  system clock, all logic on rising edge
- Rst  input  1  reset, synchronous, active-high
- i_Req  input  N_REQ  request; bit k high means requester k has a valid byte on its data slice
- i_Data  input  8*N_REQ  byte for requester k on bits [8k+7:8k]
- i_Last  input  N_REQ  bit k high means the current byte of requester k ends its packet
- o_Grant  output  N_REQ  one-hot owner of the transmitter, zero when idle
- o_Ack  output  N_REQ  one-cycle pulse; bit k means byte of requester k accepted, requester may change data/last next cycle
- o_Abort  output  N_REQ  one-cycle pulse; bit k means grant of requester k revoked by hold timeout
- o_TxStart  output  1  one-cycle start pulse to transmitter
- o_TxData  output  8  byte to transmitter, valid while o_TxStart high, held until next start
- i_TxBusy  input  1  transmitter busy; rises 1..4 cycles after o_TxStart, falls after the stop bit

## Operation
- Registers: state, o_Grant, rr pointer (index of last owner), latched last flag, hold counter of ceil(log2(HOLD_TO+1)) bits.
- IDLE: if any i_Req bit set, grant the first set bit scanning from pointer+1 upward with wrap, and go to LOAD. Otherwise stay.
- LOAD: if i_Req[g] high and i_TxBusy low, pulse o_TxStart and o_Ack[g], load o_TxData from slice g, latch i_Last[g], clear hold counter, and go to WAIT_HI. If i_Req[g] is low, increment the hold counter. When it reaches HOLD_TO, pulse o_Abort[g], clear o_Grant, set pointer=g, and go to IDLE.
- WAIT_HI: wait for i_TxBusy high, then go to WAIT_LO. Grant stays held.
- WAIT_LO: on i_TxBusy low, if the latched last flag is set, clear o_Grant, set pointer=g, and go to IDLE. Otherwise go to LOAD with the grant held.
- Non-granted requesters are never acked. Their request lines may toggle freely.
- Requests arriving in the same cycle are resolved only by the rr pointer. No requester wins twice in a row while another is requesting.
- i_Last on a non-granted slice has no effect.

## Timing
- Reset values: o_Grant=0, o_Ack=0, o_Abort=0, o_TxStart=0, o_TxData=8'h00, state IDLE, pointer=N_REQ-1 (requester 0 first), hold counter 0, last flag 0.
- Rst high in any state returns all of the above on the next edge. An in-flight transmitter byte is not cancelled. After reset the arbiter starts in IDLE regardless of i_TxBusy.
- Req to grant: 1 cycle. Grant to o_TxStart: 1 cycle if i_TxBusy is low, so the earliest start is 2 cycles after the request.
- o_Ack and o_TxStart are coincident, exactly one cycle wide.
- Back-to-back bytes of one packet: next o_TxStart comes 1 cycle after the cycle where i_TxBusy is sampled low in WAIT_LO, provided i_Req[g] is high.
- Grant release to next grant: IDLE takes 1 cycle, so a competing requester is granted 1 cycle after release.
- The hold counter counts only in LOAD while i_Req[g] is low. It is not reset by i_Req rising without an accept.
- If i_TxBusy is already high on entry to LOAD, no start is issued until it falls.

## Test plan
- Single byte: req0 with data 8'h3C and last=1 after reset. Required: o_Grant=0001 one cycle later, then o_TxStart with o_TxData=8'h3C and o_Ack=0001 one cycle after that. Grant clears once busy falls.
- Round-robin: req0 and req2 set in the same cycle, each with a one-byte packet, both held. Required order of grants is 0, 2, 0, 2, with pointer wrap verified.
- Packet lock: req1 sends 8'hE5, 8'h01, 8'h02 with last on the third byte, while req3 requests throughout. Required: three starts for requester 1 with no o_Grant[3] in between, then requester 3 is granted.
- Hold timeout: with HOLD_TO=16, req1 sends one non-last byte, then drops its request. Required: o_Abort=0010 for one cycle 16 cycles after entering LOAD, then o_Grant=0 and the next requester is served.
- Busy stall: hold i_TxBusy high while req0 is granted. Required: no o_TxStart until busy falls, then the start is issued 1 cycle later.
- Reset mid-packet: assert Rst during WAIT_LO of a 3-byte packet. Required: all outputs take their reset values on the next edge, and after release requester 0 has first priority.
